// File: rtl/posit_to_double_es3.sv
// posit<32,3> to IEEE-754 binary64 converter.
// Four register ranks: input capture, magnitude/regime decode, field extraction,
// and double assembly. One conversion per cycle; done arrives three edges after
// the edge that sampled start. Every posit<32,3> value fits exactly in binary64,
// so no rounding logic is needed.
module posit_to_double_es3 (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] in,
    output logic [63:0] result,
    output logic        zero,
    output logic        nar,
    output logic        done
);

    localparam int unsigned NBITS = 32;
    localparam int unsigned ES    = 3;
    localparam int unsigned DBITS = 64;
    localparam int unsigned FBITS = NBITS - ES - 3;  // widest fraction: 26 bits

    localparam logic [DBITS-1:0] QuietNan = 64'h7FF8_0000_0000_0000;
    localparam logic [10:0]      ExpBias  = 11'd1023;

    // ------------------------------------------------------------------
    // S0: input capture
    // ------------------------------------------------------------------
    logic             s0_valid_q, s0_valid_d;
    logic [NBITS-1:0] s0_in_q, s0_in_d;

    // Next state for the input rank.
    always_comb begin
        s0_valid_d = start;
        s0_in_d    = in;
    end

    // Input rank; reset drops any start presented in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            s0_valid_q <= 1'b0;
            s0_in_q    <= '0;
        end else begin
            s0_valid_q <= s0_valid_d;
            s0_in_q    <= s0_in_d;
        end
    end

    // ------------------------------------------------------------------
    // S1: sign, magnitude, specials, regime run length
    // ------------------------------------------------------------------
    logic             s1_valid_q, s1_valid_d;
    logic             s1_sign_q, s1_sign_d;
    logic             s1_zero_q, s1_zero_d;
    logic             s1_nar_q, s1_nar_d;
    logic [30:0]      s1_body_q, s1_body_d;   // magnitude without its sign bit
    logic [4:0]       s1_run_q, s1_run_d;     // regime run length m, 1..31
    logic             s1_rbit_q, s1_rbit_d;   // value of the regime bits

    logic [NBITS-1:0] s1_abs;
    logic             s1_run_open;
    logic             unused_abs_msb;

    // Two's-complement magnitude, special detection and leading-run count.
    always_comb begin
        s1_valid_d = s0_valid_q;
        s1_sign_d  = s0_in_q[NBITS-1];
        s1_abs     = s0_in_q[NBITS-1] ? (~s0_in_q + 32'd1) : s0_in_q;
        s1_zero_d  = (s0_in_q == 32'h0000_0000);
        s1_nar_d   = (s0_in_q == 32'h8000_0000);
        s1_body_d  = s1_abs[30:0];
        s1_rbit_d  = s1_abs[30];

        // Count bits equal to abs[30] from the top down until the first change.
        s1_run_d    = '0;
        s1_run_open = 1'b1;
        for (int i = 30; i >= 0; i--) begin
            if (s1_run_open && (s1_abs[i] == s1_abs[30])) begin
                s1_run_d = s1_run_d + 5'd1;
            end else begin
                s1_run_open = 1'b0;
            end
        end
    end

    // abs[31] is only set for NaR, which is handled through the special flag.
    assign unused_abs_msb = s1_abs[31];

    // Decode rank.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_zero_q  <= 1'b0;
            s1_nar_q   <= 1'b0;
            s1_body_q  <= '0;
            s1_run_q   <= '0;
            s1_rbit_q  <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sign_q  <= s1_sign_d;
            s1_zero_q  <= s1_zero_d;
            s1_nar_q   <= s1_nar_d;
            s1_body_q  <= s1_body_d;
            s1_run_q   <= s1_run_d;
            s1_rbit_q  <= s1_rbit_d;
        end
    end

    // ------------------------------------------------------------------
    // S2: strip regime + terminator, extract exponent and fraction, scale
    // ------------------------------------------------------------------
    logic             s2_valid_q, s2_valid_d;
    logic             s2_sign_q, s2_sign_d;
    logic             s2_zero_q, s2_zero_d;
    logic             s2_nar_q, s2_nar_d;
    logic [9:0]       s2_scale_q, s2_scale_d;  // two's complement, [-240, 240]
    logic [FBITS-1:0] s2_frac_q, s2_frac_d;

    logic [5:0]       s2_shamt;
    logic [63:0]      s2_shifted;
    logic [28:0]      s2_fields;
    logic [ES-1:0]    s2_exp;
    logic [9:0]       s2_run_ext;
    logic [9:0]       s2_k;
    logic [34:0]      unused_shift_tail;

    // Left-justify the bits after the terminator; bits shifted past the end read as 0.
    always_comb begin
        s2_valid_d = s1_valid_q;
        s2_sign_d  = s1_sign_q;
        s2_zero_d  = s1_zero_q;
        s2_nar_d   = s1_nar_q;

        // Run of m bits plus the terminator; for m=31 there is no terminator,
        // but everything is shifted out either way.
        s2_shamt   = {1'b0, s1_run_q} + 6'd1;
        s2_shifted = {s1_body_q, 33'b0} << s2_shamt;
        s2_fields  = s2_shifted[63:35];
        s2_exp     = s2_fields[28:26];
        s2_frac_d  = s2_fields[25:0];

        // k = m-1 for a run of ones, -m for a run of zeros.
        s2_run_ext = {5'd0, s1_run_q};
        s2_k       = s1_rbit_q ? (s2_run_ext - 10'd1) : (10'd0 - s2_run_ext);
        s2_scale_d = (s2_k << ES) + {7'd0, s2_exp};
    end

    assign unused_shift_tail = s2_shifted[34:0];

    // Field-extraction rank.
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid_q <= 1'b0;
            s2_sign_q  <= 1'b0;
            s2_zero_q  <= 1'b0;
            s2_nar_q   <= 1'b0;
            s2_scale_q <= '0;
            s2_frac_q  <= '0;
        end else begin
            s2_valid_q <= s2_valid_d;
            s2_sign_q  <= s2_sign_d;
            s2_zero_q  <= s2_zero_d;
            s2_nar_q   <= s2_nar_d;
            s2_scale_q <= s2_scale_d;
            s2_frac_q  <= s2_frac_d;
        end
    end

    // ------------------------------------------------------------------
    // S3: assemble binary64; outputs hold between valid items
    // ------------------------------------------------------------------
    logic [DBITS-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             nar_q, nar_d;
    logic             done_q, done_d;
    logic [10:0]      s3_biased;

    // Output next state; scale range keeps the biased exponent in 783..1263.
    always_comb begin
        result_d  = result_q;
        zero_d    = zero_q;
        nar_d     = nar_q;
        done_d    = s2_valid_q;
        s3_biased = {s2_scale_q[9], s2_scale_q} + ExpBias;

        if (s2_valid_q) begin
            if (s2_nar_q) begin
                result_d = QuietNan;
                zero_d   = 1'b0;
                nar_d    = 1'b1;
            end else if (s2_zero_q) begin
                result_d = '0;
                zero_d   = 1'b1;
                nar_d    = 1'b0;
            end else begin
                result_d = {s2_sign_q, s3_biased, s2_frac_q, 26'd0};
                zero_d   = 1'b0;
                nar_d    = 1'b0;
            end
        end
    end

    // Output rank.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_q <= '0;
            zero_q   <= 1'b0;
            nar_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
            nar_q    <= nar_d;
            done_q   <= done_d;
        end
    end

    assign result = result_q;
    assign zero   = zero_q;
    assign nar    = nar_q;
    assign done   = done_q;

endmodule

// File: tb/tb_posit_to_double_es3.sv
// Scoreboard bench for posit_to_double_es3: the driver pushes expected results,
// and an independent monitor pops and compares them whenever done is seen.
module tb_posit_to_double_es3;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] in_w;
    logic [63:0] result;
    logic        zero;
    logic        nar;
    logic        done;

    always #5 clk = ~clk;

    posit_to_double_es3 dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .in     (in_w),
        .result (result),
        .zero   (zero),
        .nar    (nar),
        .done   (done)
    );

    typedef struct {
        logic [63:0] res;
        logic        z;
        logic        n;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_sent   = 0;
    int   n_done   = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check64(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, got, want);
    endtask

    // Reference: walk the posit bits one at a time and build the value as a real.
    function automatic void model(input logic [31:0] p, output logic [63:0] r,
                                  output logic z, output logic n);
        logic [31:0] a;
        logic        s;
        logic        rb;
        int          i, m, k, e, scale;
        real         frac, w, pw, v;
        z = 1'b0;
        n = 1'b0;
        if (p == 32'h0) begin
            r = 64'h0;
            z = 1'b1;
            return;
        end
        if (p == 32'h8000_0000) begin
            r = 64'h7FF8_0000_0000_0000;
            n = 1'b1;
            return;
        end
        s  = p[31];
        a  = s ? (32'd0 - p) : p;
        rb = a[30];
        i  = 30;
        m  = 0;
        while (i >= 0 && a[i] == rb) begin
            m++;
            i--;
        end
        k = rb ? m - 1 : -m;
        i--;                              // terminator
        e = 0;
        for (int j = 0; j < 3; j++) begin
            e = e * 2;
            if (i >= 0) begin
                e = e + int'(a[i]);
                i--;
            end
        end
        frac = 0.0;
        w    = 0.5;
        while (i >= 0) begin
            if (a[i]) frac = frac + w;
            w = w / 2.0;
            i--;
        end
        scale = 8 * k + e;
        pw    = 1.0;
        if (scale >= 0) repeat (scale) pw = pw * 2.0;
        else repeat (-scale) pw = pw * 0.5;
        v = (1.0 + frac) * pw;
        if (s) v = -v;
        r = $realtobits(v);
    endfunction

    task automatic send(input logic [31:0] v, input logic [63:0] r, input logic z,
                        input logic n);
        exp_t x;
        @(posedge clk);
        #1;
        start = 1'b1;
        in_w  = v;
        x.res = r;
        x.z   = z;
        x.n   = n;
        x.cyc = cyc;
        sb_q.push_back(x);
        n_sent++;
    endtask

    task automatic send_model(input logic [31:0] v);
        logic [63:0] r;
        logic        z, n;
        model(v, r, z, n);
        send(v, r, z, n);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) idle();
        #2;
    endtask

    // Monitor: every done must match the oldest outstanding expectation.
    always @(posedge clk) begin
        exp_t x;
        #1;
        if (done === 1'b1) begin
            n_done++;
            if (sb_q.size() == 0) begin
                check64("spurious_done", {63'd0, done}, 64'd0);
            end else begin
                x = sb_q.pop_front();
                check64("result", result, x.res);
                check64("zero_nar", {62'd0, zero, nar}, {62'd0, x.z, x.n});
                check64("latency", 64'(cyc), 64'(x.cyc + 4));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int done_before;
        reset = 1'b1;
        start = 1'b0;
        in_w  = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check64("rst_done", {63'd0, done}, 64'd0);
        check64("rst_result", result, 64'h0);
        check64("rst_zero", {63'd0, zero}, 64'd0);
        check64("rst_nar", {63'd0, nar}, 64'd0);
        reset = 1'b0;

        // Single 1.0
        send(32'h4000_0000, 64'h3FF0_0000_0000_0000, 1'b0, 1'b0);
        idle();
        drain();

        // Back-to-back
        send(32'h4200_0000, 64'h3FF8_0000_0000_0000, 1'b0, 1'b0);
        send(32'h4800_0000, 64'h4010_0000_0000_0000, 1'b0, 1'b0);
        send(32'hC000_0000, 64'hBFF0_0000_0000_0000, 1'b0, 1'b0);
        idle();
        drain();

        // Extremes, specials and a few field shapes
        send(32'h7FFF_FFFF, 64'h4EF0_0000_0000_0000, 1'b0, 1'b0);
        send(32'h0000_0001, 64'h30F0_0000_0000_0000, 1'b0, 1'b0);
        send(32'h8000_0001, 64'hCEF0_0000_0000_0000, 1'b0, 1'b0);
        send(32'h0000_0000, 64'h0000_0000_0000_0000, 1'b1, 1'b0);
        send(32'h8000_0000, 64'h7FF8_0000_0000_0000, 1'b0, 1'b1);
        send(32'h4000_0001, 64'h3FF0_0000_0400_0000, 1'b0, 1'b0);
        send(32'h3800_0000, 64'h3FD0_0000_0000_0000, 1'b0, 1'b0);
        send(32'hC800_0000, 64'hBFD0_0000_0000_0000, 1'b0, 1'b0);
        idle();
        drain();

        // Reset with items in flight; reset also wins over a concurrent start
        done_before = n_done;
        @(posedge clk); #1; start = 1'b1; in_w = 32'h4800_0000;
        @(posedge clk); #1; start = 1'b1; in_w = 32'hC000_0000;
        @(posedge clk); #1; reset = 1'b1; start = 1'b1; in_w = 32'h4200_0000;
        @(posedge clk); #1; reset = 1'b0; start = 1'b0;
        repeat (6) idle();
        #2;
        check64("reset_discard", 64'(n_done - done_before), 64'd0);
        check64("post_rst_result", result, 64'h0);
        check64("post_rst_flags", {62'd0, zero, nar}, 64'd0);

        send(32'h4000_0000, 64'h3FF0_0000_0000_0000, 1'b0, 1'b0);
        idle();
        drain();
        repeat (5) idle();
        #2;
        check64("hold_result", result, 64'h3FF0_0000_0000_0000);
        check64("hold_done", {63'd0, done}, 64'd0);

        // Random sweep with idle gaps
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 3) == 0) idle();
            else send_model($urandom);
        end
        idle();
        drain();

        check64("sb_empty", 64'(sb_q.size()), 64'd0);
        check64("done_count", 64'(n_done), 64'(n_sent));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
